// File: rtl/fmax_reduce_6_6.sv
// Streaming max/argmax reduction over groups of N FloPoCo (wE=6, wF=6) operands on one shared comparator.
// Define FMAX_REDUCE_MIN_EN to swap the comparator operands and reduce to the minimum instead.

module fmax_reduce_6_6_fcmplt (
    input  logic [14:0] i_x,
    input  logic [14:0] i_y,
    output logic        o_xlty,
    output logic        o_unordered
);
    // Map each operand onto a signed total-order key: zeros collapse to 0,
    // infinities sit beyond the largest normal magnitude.
    function automatic logic signed [14:0] ord_key(input logic [14:0] v);
        logic [13:0] mag;
        case (v[14:13])
            2'b00:   mag = 14'd0;
            2'b01:   mag = {2'b00, v[11:0]} + 14'd1;
            default: mag = 14'h2000;
        endcase
        ord_key = v[12] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic signed [14:0] w_key_x;
    logic signed [14:0] w_key_y;

    assign w_key_x     = ord_key(i_x);
    assign w_key_y     = ord_key(i_y);
    assign o_unordered = (i_x[14:13] == 2'b11) || (i_y[14:13] == 2'b11);
    assign o_xlty      = !o_unordered && (w_key_x < w_key_y);
endmodule

module fmax_reduce_6_6 #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nan,
    output logic             busy
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // a producer holds valid and data stable until that edge, ready may change freely.
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [14:0]        r_best;
    logic [IDX_W-1:0]   r_best_idx;
    logic               r_nan_flag;
    logic               w_take;
    logic               w_xlty;
    logic               w_unordered;
    logic               w_in_nan;
    logic [14:0]        w_cmp_x;
    logic [14:0]        w_cmp_y;

`ifdef FMAX_REDUCE_MIN_EN
    assign w_cmp_x = in_data;
    assign w_cmp_y = r_best;
`else
    assign w_cmp_x = r_best;
    assign w_cmp_y = in_data;
`endif

    fmax_reduce_6_6_fcmplt u_cmp (
        .i_x         (w_cmp_x),
        .i_y         (w_cmp_y),
        .o_xlty      (w_xlty),
        .o_unordered (w_unordered)
    );

    assign w_in_nan = (in_data[14:13] == 2'b11);
    assign w_take   = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                // Held low while reset is asserted so nothing is offered as accepted.
                in_ready = !rst;
                if (in_valid && !rst && (r_cnt == LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_nan_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                if (r_cnt == '0) begin
                    r_best     <= in_data;
                    r_best_idx <= '0;
                    r_nan_flag <= w_in_nan;
                end else begin
                    // Unordered never updates, so ties and NaNs keep the earlier operand.
                    if (!w_unordered && w_xlty) begin
                        r_best     <= in_data;
                        r_best_idx <= r_cnt;
                    end
                    if (w_in_nan) begin
                        r_nan_flag <= 1'b1;
                    end
                end
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + IDX_W'(1);
            end
        end
    end

    assign out_max = r_best;
    assign out_idx = r_best_idx;
    assign out_nan = r_nan_flag;
    assign busy    = (r_state == ACCUM) && (r_cnt != '0);
endmodule

// File: tb/tb_fmax_reduce_6_6.sv
// Bench for fmax_reduce_6_6: directed and random groups against a real-valued reduction model.
module tb_fmax_reduce_6_6;
  localparam int N = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [14:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [14:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic             out_nan;
  logic             busy;

  int n_checks = 0;
  int n_pass = 0;
  logic [17:0] exp_q[$];
  logic [14:0] grp[N];

  fmax_reduce_6_6 #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_nan(out_nan), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model: operands as real numbers
  function automatic bit is_nan(input logic [14:0] v);
    return v[14:13] == 2'b11;
  endfunction

  function automatic real fval(input logic [14:0] v);
    real m;
    int e;
    case (v[14:13])
      2'b00: m = 0.0;
      2'b01: begin
        m = 1.0 + real'(int'(v[5:0])) / 64.0;
        e = int'(v[11:6]) - 31;
        if (e > 0) repeat (e) m = m * 2.0;
        else repeat (-e) m = m / 2.0;
      end
      default: m = 1.0e30;
    endcase
    return v[12] ? -m : m;
  endfunction

  function automatic bit better(input logic [14:0] cand, input logic [14:0] cur);
`ifdef FMAX_REDUCE_MIN_EN
    return fval(cand) < fval(cur);
`else
    return fval(cand) > fval(cur);
`endif
  endfunction

  task automatic model_push();
    logic [14:0] b;
    logic [IDX_W-1:0] bi;
    bit nan;
    b = grp[0];
    bi = '0;
    nan = is_nan(grp[0]);
    for (int i = 1; i < N; i++) begin
      if (is_nan(grp[i])) nan = 1'b1;
      else if (!is_nan(b) && better(grp[i], b)) begin
        b = grp[i];
        bi = IDX_W'(i);
      end
    end
    exp_q.push_back({nan, bi, b});
  endtask

  function automatic logic [14:0] rand_op();
    int r;
    logic [14:0] v;
    r = $urandom_range(0, 19);
    v = 15'($urandom);
    if (r == 0) v[14:13] = 2'b11;
    else if (r <= 2) v[14:13] = 2'b10;
    else if (r <= 4) v[14:13] = 2'b00;
    else begin
      v[14:13] = 2'b01;
      v[11:6] = 6'($urandom_range(29, 33));
      if ($urandom_range(0, 1) == 1) v[5:0] = 6'($urandom_range(0, 3) * 16);
    end
    return v;
  endfunction

  // drivers
  task automatic send(input logic [14:0] d, input int bubbles, input int pos);
    int guard;
    repeat (bubbles) begin
      in_valid = 1'b0;
      in_data = 15'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = d;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 15'($urandom);
    if (pos < N - 1) check("busy_mid", 32'(busy), 32'd1);
    else check("out_valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic run_group(input int hold, input int max_bubble);
    logic [17:0] e;
    int guard;
    model_push();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(grp[i], $urandom_range(0, max_bubble), i);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("out_valid_wait", 32'(out_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
    check("out_max", 32'(out_max), 32'(e[14:0]));
    check("out_idx", 32'(out_idx), 32'(e[16:15]));
    check("out_nan", 32'(out_nan), 32'(e[17]));
    check("busy_done", 32'(busy), 32'd0);
    repeat (hold) begin
      in_valid = 1'($urandom);
      in_data = 15'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_max", 32'({out_nan, out_idx, out_max}), 32'(e));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic set_grp(input logic [14:0] a, input logic [14:0] b,
                         input logic [14:0] c, input logic [14:0] d);
    grp[0] = a; grp[1] = b; grp[2] = c; grp[3] = d;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({out_nan, out_idx, out_max}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    set_grp(15'h27C0, 15'h2800, 15'h3820, 15'h27C0); run_group(0, 0);
    set_grp(15'h5000, 15'h3820, 15'h4000, 15'h2800); run_group(0, 0);
    set_grp(15'h1000, 15'h0000, 15'h1000, 15'h3820); run_group(0, 0);
    set_grp(15'h27C0, 15'h6000, 15'h2800, 15'h3820); run_group(0, 0);
    set_grp(15'h27C0, 15'h27C0, 15'h27C0, 15'h27C0); run_group(0, 0);
    set_grp(15'h6000, 15'h2800, 15'h4000, 15'h27C0); run_group(0, 0);
    set_grp(15'h3820, 15'h27C0, 15'h2800, 15'h5000); run_group(5, 3);

    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < N; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) grp[i] = grp[$urandom_range(0, i - 1)];
        else grp[i] = rand_op();
      end
      run_group($urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset in the middle of a group discards the partial operands
    out_ready = 1'b0;
    send(15'h4000, 0, 0);
    send(15'h6000, 1, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_outputs", 32'({out_valid, out_nan, out_idx, out_max}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_grp(15'h3820, 15'h27C0, 15'h2800, 15'h5000); run_group(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
